uart_tx_serializer: RTL and testbench

- Byte-level UART transmitter sitting directly downstream of the result-transmission controller.
- Accepts one byte plus a one-cycle start strobe and serializes it onto the TX line: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Exposes a busy flag the controller polls between consecutive bytes.

---
 rtl/uart_tx_serializer.sv | 151 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// Byte-level UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. All outputs are registered from the next-state decode.
module uart_tx_serializer #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam bit          PAR_EN       = (PARITY == 1) || (PARITY == 2);
  localparam bit          PAR_ODD      = (PARITY == 1);
  localparam int unsigned STOPS        = (STOP_BITS == 2) ? 2 : 1;
  localparam int unsigned STOP_CLKS    = STOPS * CLKS_PER_BIT;
  localparam int unsigned CW           = $clog2(STOP_CLKS + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, cnt_n;
  logic [2:0]    bit_idx, idx_n;
  logic [7:0]    shift_reg, shift_n;
  logic          par_acc, par_n;
  logic          tx_n, busy_n, done_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      par_acc   <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= cnt_n;
      bit_idx   <= idx_n;
      shift_reg <= shift_n;
      par_acc   <= par_n;
      tx        <= tx_n;
      tx_busy   <= busy_n;
      tx_done   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = baud_cnt + CNT_ONE;
    idx_n   = bit_idx;
    shift_n = shift_reg;
    par_n   = par_acc;

    unique case (state)
      // DONE accepts a strobe exactly like IDLE so frames can run back to back
      ST_IDLE, ST_DONE: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
        if (tx_start) begin
          shift_n = tx_data;
          par_n   = 1'b0;
          idx_n   = '0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (baud_cnt == BIT_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift_reg[7:1]};
          par_n   = par_acc ^ shift_reg[0];
          idx_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = PAR_EN ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (baud_cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_cnt == STOP_LAST) begin
          cnt_n   = '0;
          state_n = ST_DONE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase

    // Outputs decode the next state so each register lines up with its state
    tx_n   = 1'b1;
    busy_n = 1'b0;
    done_n = 1'b0;
    unique case (state_n)
      ST_START: begin
        tx_n   = 1'b0;
        busy_n = 1'b1;
      end
      ST_DATA: begin
        tx_n   = shift_n[0];
        busy_n = 1'b1;
      end
      ST_PARITY: begin
        tx_n   = par_n ^ PAR_ODD;
        busy_n = 1'b1;
      end
      ST_STOP: begin
        busy_n = 1'b1;
      end
      ST_DONE: begin
        done_n = 1'b1;
      end
      default: begin
        tx_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: vector table plus hand-written
// back-to-back, ignored-strobe and mid-frame reset sequences, checked via a bit queue.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] tx_start_v;
  logic [7:0] tx_data;
  logic [3:0] tx_v, busy_v, done_v;

  int checks   = 0;
  int failures = 0;

  // Clocks per bit for each instance: 1e8/115200=868, 1e8/3e7=3 (truncated), 1e8/5e7=2
  int cpb_of [4] = '{868, 3, 2, 868};

  typedef struct {
    logic val;
    bit   last;
  } exp_bit_t;
  exp_bit_t exp_q[$];

  typedef struct {
    int         sel;
    logic [7:0] data;
    bit         has_par;
    logic       par_bit;
    int         nbits;
  } vec_t;
  vec_t vecs[11];

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_FREQ(100000000), .BAUD_RATE(115200), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .tx_start(tx_start_v[0]), .tx_data(tx_data),
    .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx_serializer #(.CLK_FREQ(100000000), .BAUD_RATE(30000000), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .tx_start(tx_start_v[1]), .tx_data(tx_data),
    .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx_serializer #(.CLK_FREQ(100000000), .BAUD_RATE(50000000), .PARITY(1), .STOP_BITS(3)) u2 (
    .clk(clk), .reset(reset), .tx_start(tx_start_v[2]), .tx_data(tx_data),
    .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx_serializer #(.CLK_FREQ(100000000), .BAUD_RATE(115200), .PARITY(3), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .tx_start(tx_start_v[3]), .tx_data(tx_data),
    .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Called at a negedge: raise the strobe and queue the expected line bits.
  task automatic strobe(input int sel, input logic [7:0] b, input bit has_par,
                        input logic par_bit, input int nbits);
    exp_bit_t e;
    tx_start_v[sel] = 1'b1;
    tx_data         = b;
    e.last = 1'b0;
    e.val  = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.val = b[i];
      exp_q.push_back(e);
    end
    if (has_par) begin
      e.val = par_bit;
      exp_q.push_back(e);
    end
    for (int i = 9 + int'(has_par); i < nbits; i++) begin
      e.val  = 1'b1;
      e.last = (i == nbits - 1);
      exp_q.push_back(e);
    end
  endtask

  // Follows one frame cycle by cycle, popping expected bits; returns at the DONE
  // negedge (idle_after=0) or after an idle window.
  task automatic run_frame(input int sel, input string tag, input bit idle_after, input bit inject);
    int         cpb;
    int         k;
    exp_bit_t   e;
    logic       a_tx, a_busy, a_done;
    logic [2:0] a_idle;
    cpb = cpb_of[sel];
    @(negedge clk);
    tx_start_v[sel] = 1'b0;
    tx_data         = ~tx_data;
    chk({tag, "_busy_rise"}, 32'(busy_v[sel]), 32'd1);
    a_busy = 1'b1;
    a_done = 1'b0;
    k      = 0;
    do begin
      e    = exp_q.pop_front();
      a_tx = e.val;
      for (int c = 0; c < cpb; c++) begin
        if (tx_v[sel] !== e.val) a_tx = tx_v[sel];
        if (busy_v[sel] !== 1'b1) a_busy = busy_v[sel];
        if (done_v[sel] !== 1'b0) a_done = done_v[sel];
        tx_start_v[sel] = (inject && k == 5 && c == 0);
        if (inject && k == 5 && c == 0) tx_data = 8'h00;
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, k), 32'(a_tx), 32'(e.val));
      k++;
    end while (!e.last);
    chk({tag, "_busy_frame"}, 32'(a_busy), 32'd1);
    chk({tag, "_done_early"}, 32'(a_done), 32'd0);
    chk({tag, "_done_pulse"}, 32'({tx_v[sel], busy_v[sel], done_v[sel]}), 32'b101);
    if (idle_after) begin
      a_idle = 3'b100;
      for (int c = 0; c < cpb + 2; c++) begin
        @(negedge clk);
        if ({tx_v[sel], busy_v[sel], done_v[sel]} !== 3'b100)
          a_idle = {tx_v[sel], busy_v[sel], done_v[sel]};
      end
      chk({tag, "_idle"}, 32'(a_idle), 32'b100);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    tx_start_v = '0;
    tx_data    = '0;
    #2 reset = 1'b0;

    vecs[0]  = '{0, 8'hA5, 1'b0, 1'b0, 10};
    vecs[1]  = '{1, 8'h07, 1'b1, 1'b1, 11};
    vecs[2]  = '{1, 8'h00, 1'b1, 1'b0, 11};
    vecs[3]  = '{1, 8'hFF, 1'b1, 1'b0, 11};
    vecs[4]  = '{1, 8'h80, 1'b1, 1'b1, 11};
    vecs[5]  = '{1, 8'h3C, 1'b1, 1'b0, 11};
    vecs[6]  = '{2, 8'h07, 1'b1, 1'b0, 11};
    vecs[7]  = '{2, 8'h00, 1'b1, 1'b1, 11};
    vecs[8]  = '{2, 8'hFF, 1'b1, 1'b1, 11};
    vecs[9]  = '{2, 8'h01, 1'b1, 1'b0, 11};
    vecs[10] = '{3, 8'hFF, 1'b0, 1'b0, 11};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset_state_u%0d", i), 32'({tx_v[i], busy_v[i], done_v[i]}), 32'b100);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("idle_u%0d", i), 32'({tx_v[i], busy_v[i], done_v[i]}), 32'b100);

    foreach (vecs[i]) begin
      strobe(vecs[i].sel, vecs[i].data, vecs[i].has_par, vecs[i].par_bit, vecs[i].nbits);
      run_frame(vecs[i].sel, $sformatf("vec%0d", i), 1'b1, 1'b0);
    end

    // Back-to-back: second strobe lands in the DONE cycle of the first frame
    strobe(0, 8'h11, 1'b0, 1'b0, 10);
    run_frame(0, "b2b_11", 1'b0, 1'b0);
    strobe(0, 8'h22, 1'b0, 1'b0, 10);
    run_frame(0, "b2b_22", 1'b1, 1'b0);

    // Strobe with 0x00 during data bit 4 must be ignored
    strobe(0, 8'h3C, 1'b0, 1'b0, 10);
    run_frame(0, "ign_3c", 1'b1, 1'b1);

    // Reset in the middle of data bit 4 (0x0F has bit 4 low)
    strobe(0, 8'h0F, 1'b0, 1'b0, 10);
    @(negedge clk);
    tx_start_v[0] = 1'b0;
    repeat (5 * 868 + 400) @(negedge clk);
    chk("rst_pre_bit4", 32'({tx_v[0], busy_v[0]}), 32'b01);
    #2 reset = 1'b0;
    #1 chk("rst_async", 32'({tx_v[0], busy_v[0], done_v[0]}), 32'b100);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("rst_hold", 32'({tx_v[0], busy_v[0], done_v[0]}), 32'b100);
    reset = 1'b1;
    @(negedge clk);
    strobe(0, 8'h55, 1'b0, 1'b0, 10);
    run_frame(0, "post_rst_55", 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
